alu_modport: RTL and testbench



---
 rtl/alu_modport_if.sv | 16 +
 rtl/alu_modport.sv | 58 +++++
 tb/tb_alu_modport.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_modport_if.sv
// Bundles the ALU operands, opcode and registered result.
// master drives operations, slave is the ALU itself, monitor only observes.
interface alu_modport_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int RES_W = WIDTH + 2
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SEL_W-1:0] sel;
  logic [RES_W-1:0] result;

  modport master  (output A, output B, output sel, input result);
  modport slave   (input A, input B, input sel, output result);
  modport monitor (input A, input B, input sel, input result);
endinterface

// File: rtl/alu_modport.sv
// Registered 4-bit ALU: result is f(A, B, sel) sampled one clock earlier.
// Operands are zero-extended to RES_W so ADD/INC never overflow and SUB/MUL wrap mod 2^RES_W.
module alu_modport #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int RES_W = WIDTH + 2
) (
  input logic         clk,
  input logic         reset,
  alu_modport_if.slave bus
);

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_NOT = 3'd6,
    OP_INC = 3'd7
  } op_t;

  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_b;
  logic [RES_W-1:0] w_next;
  logic [RES_W-1:0] r_result;

  assign w_a = {{(RES_W-WIDTH){1'b0}}, bus.A};
  assign w_b = {{(RES_W-WIDTH){1'b0}}, bus.B};

  always_comb begin
    w_next = '0;
    case (bus.sel)
      OP_ADD: w_next = w_a + w_b;
      OP_SUB: w_next = w_a - w_b;
      OP_MUL: w_next = w_a * w_b;
      OP_AND: w_next = w_a & w_b;
      OP_OR:  w_next = w_a | w_b;
      OP_XOR: w_next = w_a ^ w_b;
      OP_NOT: w_next = {{(RES_W-WIDTH){1'b0}}, ~bus.A};
      OP_INC: w_next = w_a + RES_W'(1);
      default: w_next = '0;
    endcase
  end

  // Only the register drives the output, so there is no input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else begin
      r_result <= w_next;
    end
  end

  assign bus.result = r_result;

endmodule

// File: tb/tb_alu_modport.sv
// Directed and exhaustive self-checking bench for the registered ALU.
module tb_alu_modport;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_modport_if #(.WIDTH(4), .SEL_W(3), .RES_W(6)) bus ();

  alu_modport #(.WIDTH(4), .SEL_W(3), .RES_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    bus.A   = a;
    bus.B   = b;
    bus.sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    checks++;
    assert (bus.result === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, bus.result, expected);
    end
  endtask

  // Independent reference written in plain integer arithmetic.
  function automatic logic [5:0] refModel(input int a, input int b, input int s);
    int r;
    case (s)
      0: r = a + b;
      1: r = (a - b + 64) % 64;
      2: r = (a * b) % 64;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 15 - a;
      default: r = a + 1;
    endcase
    return r[5:0];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    applyStimulus(4'd15, 4'd15, 3'b000);
    checkOutput("reset_edge1", 6'd0);
    applyStimulus(4'd15, 4'd15, 3'b000);
    checkOutput("reset_edge2", 6'd0);
    reset = 1'b0;
    applyStimulus(4'd15, 4'd15, 3'b000);
    checkOutput("first_after_reset_add", 6'd30);

    applyStimulus(4'd9, 4'd6, 3'b000);
    checkOutput("add_9_6", 6'd15);
    applyStimulus(4'd3, 4'd5, 3'b001);
    checkOutput("sub_3_5_wrap", 6'd62);
    applyStimulus(4'd10, 4'd4, 3'b001);
    checkOutput("sub_10_4", 6'd6);
    applyStimulus(4'd15, 4'd15, 3'b010);
    checkOutput("mul_15_15", 6'd33);
    applyStimulus(4'd7, 4'd9, 3'b010);
    checkOutput("mul_7_9", 6'd63);
    applyStimulus(4'd15, 4'd3, 3'b111);
    checkOutput("inc_15", 6'd16);

    applyStimulus(4'b1100, 4'b1010, 3'b011);
    checkOutput("and", 6'd8);
    applyStimulus(4'b1100, 4'b1010, 3'b100);
    checkOutput("or", 6'd14);
    applyStimulus(4'b1100, 4'b1010, 3'b101);
    checkOutput("xor", 6'd6);
    applyStimulus(4'b1100, 4'b1010, 3'b110);
    checkOutput("not", 6'd3);

    applyStimulus(4'd3, 4'd4, 3'b000);
    checkOutput("pipe_add", 6'd7);
    applyStimulus(4'd3, 4'd4, 3'b001);
    checkOutput("pipe_sub", 6'd63);
    applyStimulus(4'd3, 4'd4, 3'b010);
    checkOutput("pipe_mul", 6'd12);

    applyStimulus(4'd5, 4'd5, 3'b000);
    checkOutput("midstream_pre", 6'd10);
    reset = 1'b1;
    applyStimulus(4'd5, 4'd5, 3'b000);
    checkOutput("midstream_reset", 6'd0);
    reset = 1'b0;
    applyStimulus(4'd5, 4'd5, 3'b000);
    checkOutput("midstream_post", 6'd10);

    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(a[3:0], b[3:0], s[2:0]);
          checks++;
          assert (bus.result === refModel(a, b, s)) else begin
            errors++;
            $error("[TB] FAIL exhaustive sel=%0d A=%0d B=%0d observed=%0d expected=%0d",
                   s, a, b, bus.result, refModel(a, b, s));
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
